// File: rtl/timer_apb_multi.sv
// APB4 multi-channel timer: shared prescaler feeding NUM_CH counters, each with
// one-shot/periodic reload, up/down count, PWM compare, expiry trigger and maskable irq.

package timer_apb_multi_pkg;
  typedef struct packed {
    logic irq_en;
    logic pwm_en;
    logic up;
    logic oneshot;
    logic en;
  } ctrl_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    return r;
  endfunction
endpackage

module timer_ch import timer_apb_multi_pkg::*; #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             wr_ctrl,
  input  logic             wr_load,
  input  logic             wr_cmp,
  input  logic [31:0]      wdata,
  input  logic [3:0]       strb,
  output ctrl_t            ctrl,
  output logic [CNT_W-1:0] load,
  output logic [CNT_W-1:0] cmp,
  output logic [CNT_W-1:0] count,
  output logic             expire,
  output logic             trigger,
  output logic             pwm
);
  logic load_pend;
  logic at_end;

  assign at_end = ctrl.up ? (count == load) : (count == '0);
  // A pending LOAD_CMD owns this edge, so a coincident tick is not an expiry.
  assign expire = ctrl.en && tick && !load_pend && at_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl      <= '0;
      load      <= '0;
      cmp       <= '0;
      count     <= '0;
      load_pend <= 1'b0;
      trigger   <= 1'b0;
      pwm       <= 1'b0;
    end else begin
      if (wr_load) load <= CNT_W'(byte_merge(32'(load), wdata, strb));
      if (wr_cmp)  cmp  <= CNT_W'(byte_merge(32'(cmp), wdata, strb));
      load_pend <= wr_ctrl && strb[0] && wdata[5];

      if (load_pend || expire)
        count <= ctrl.up ? '0 : load;
      else if (ctrl.en && tick)
        count <= ctrl.up ? count + 1'b1 : count - 1'b1;

      // A software CTRL write on the expiry edge takes precedence over the one-shot stop.
      if (wr_ctrl && strb[0])
        ctrl <= ctrl_t'(wdata[4:0]);
      else if (expire && ctrl.oneshot)
        ctrl.en <= 1'b0;

      trigger <= expire;
      pwm     <= ctrl.en && ctrl.pwm_en && (count < cmp);
    end
  end
endmodule

module timer_apb_multi import timer_apb_multi_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int PRE_W  = 16,
  parameter int ADDR_W = 12
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [31:0]       pwdata,
  input  logic [3:0]        pstrb,
  output logic              pready,
  output logic [31:0]       prdata,
  output logic              pslverr,
  output logic [NUM_CH-1:0] pwm_o,
  output logic [NUM_CH-1:0] trigger_o,
  output logic              irq
);
  logic       access, aligned, is_ch, is_pre, is_ist, err, acc_ok, wr_ok;
  logic [3:0] ch_idx;
  logic [1:0] off;

  assign access  = psel && penable;
  assign ch_idx  = paddr[7:4];
  assign off     = paddr[3:2];
  assign aligned = (paddr[1:0] == 2'b00);
  assign is_ch   = (paddr[ADDR_W-1:8] == '0) && ({28'b0, ch_idx} < 32'(NUM_CH));
  assign is_pre  = (paddr == ADDR_W'(256));
  assign is_ist  = (paddr == ADDR_W'(260));
  assign err     = !aligned || !(is_ch || is_pre || is_ist) || (is_ch && off == 2'd3 && pwrite);
  assign acc_ok  = access && !err;
  assign wr_ok   = acc_ok && pwrite;

  assign pready  = 1'b1;
  assign pslverr = access && err;

  ctrl_t [NUM_CH-1:0]             ctrl;
  logic  [NUM_CH-1:0][CNT_W-1:0]  load, cmp, count;
  logic  [NUM_CH-1:0]             expire, en_vec, ie_vec;
  logic  [NUM_CH-1:0]             wr_ctrl, wr_load, wr_cmp;
  logic                           tick;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    assign sel        = wr_ok && is_ch && (ch_idx == 4'(i));
    assign wr_ctrl[i] = sel && (off == 2'd0);
    assign wr_load[i] = sel && (off == 2'd1);
    assign wr_cmp[i]  = sel && (off == 2'd2);
    assign en_vec[i]  = ctrl[i].en;
    assign ie_vec[i]  = ctrl[i].irq_en;

    timer_ch #(.CNT_W(CNT_W)) u_ch (
      .clk     (pclk),
      .rst     (preset),
      .tick    (tick),
      .wr_ctrl (wr_ctrl[i]),
      .wr_load (wr_load[i]),
      .wr_cmp  (wr_cmp[i]),
      .wdata   (pwdata),
      .strb    (pstrb),
      .ctrl    (ctrl[i]),
      .load    (load[i]),
      .cmp     (cmp[i]),
      .count   (count[i]),
      .expire  (expire[i]),
      .trigger (trigger_o[i]),
      .pwm     (pwm_o[i])
    );
  end

  logic [PRE_W-1:0] prescale, pre_cnt;
  logic             any_en, wr_pre;

  assign any_en = |en_vec;
  assign wr_pre = wr_ok && is_pre;
  assign tick   = any_en && (pre_cnt == prescale);

  always_ff @(posedge pclk) begin
    if (preset) begin
      prescale <= '0;
      pre_cnt  <= '0;
    end else begin
      if (wr_pre) prescale <= PRE_W'(byte_merge(32'(prescale), pwdata, pstrb));
      if (!any_en || wr_pre || tick) pre_cnt <= '0;
      else                           pre_cnt <= pre_cnt + 1'b1;
    end
  end

  logic [NUM_CH-1:0] int_status, w1c;

  assign w1c = (wr_ok && is_ist && pstrb[0]) ? pwdata[NUM_CH-1:0] : '0;

  // Expiry set is OR-ed in after the clear so it wins a same-edge W1C.
  always_ff @(posedge pclk) begin
    if (preset) begin
      int_status <= '0;
      irq        <= 1'b0;
    end else begin
      int_status <= (int_status & ~w1c) | expire;
      irq        <= |(int_status & ie_vec);
    end
  end

  always_comb begin
    prdata = '0;
    if (acc_ok && !pwrite) begin
      if (is_pre)
        prdata = 32'(prescale);
      else if (is_ist)
        prdata = 32'(int_status);
      else
        for (int i = 0; i < NUM_CH; i++)
          if (ch_idx == 4'(i))
            case (off)
              2'd0:    prdata = 32'(ctrl[i]);
              2'd1:    prdata = 32'(load[i]);
              2'd2:    prdata = 32'(cmp[i]);
              default: prdata = 32'(count[i]);
            endcase
    end
  end
endmodule

// File: tb/tb_timer_apb_multi.sv
// Bench for timer_apb_multi: scenario tasks checked against a spec-level cycle model.

module tb_timer_apb_multi;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int PRE_W  = 16;
  localparam int ADDR_W = 12;

  logic              pclk = 1'b0;
  logic              preset = 1'b0;
  logic [ADDR_W-1:0] paddr = '0;
  logic              psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0]       pwdata = '0;
  logic [3:0]        pstrb = '0;
  logic              pready;
  logic [31:0]       prdata;
  logic              pslverr;
  logic [NUM_CH-1:0] pwm_o, trigger_o;
  logic              irq;

  timer_apb_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W), .ADDR_W(ADDR_W)) dut (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
    .pslverr(pslverr), .pwm_o(pwm_o), .trigger_o(trigger_o), .irq(irq)
  );

  always #5 pclk = ~pclk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state (values after the most recent clock edge)
  bit [31:0]       m_load [NUM_CH], m_cmp [NUM_CH], m_count [NUM_CH];
  bit              m_en [NUM_CH], m_os [NUM_CH], m_up [NUM_CH], m_pwe [NUM_CH], m_ie [NUM_CH], m_pend [NUM_CH];
  bit [31:0]       m_ps, m_pre;
  bit [NUM_CH-1:0] m_ist, m_trig, m_pwm;
  bit              m_irq;

  function automatic bit [31:0] strb_merge(bit [31:0] old, bit [31:0] d, bit [3:0] s);
    bit [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  function automatic void m_decode(input bit [11:0] a, input bit wr, output bit err, output bit [31:0] d);
    int ch;
    ch = int'(a[11:4]);
    err = 1'b0;
    d = 32'd0;
    if (a[1:0] != 2'b00) err = 1'b1;
    else if (a == 12'h100) d = m_ps;
    else if (a == 12'h104) d = 32'(m_ist);
    else if (a < 12'h100 && ch < NUM_CH)
      case (a[3:0])
        4'h0:    d = {27'b0, m_ie[ch], m_pwe[ch], m_up[ch], m_os[ch], m_en[ch]};
        4'h4:    d = m_load[ch];
        4'h8:    d = m_cmp[ch];
        default: begin d = m_count[ch]; if (wr) err = 1'b1; end
      endcase
    else err = 1'b1;
    if (err || wr) d = 32'd0;
  endfunction

  function automatic void m_step(bit rst, bit acc, bit wr, bit [11:0] a, bit [31:0] d, bit [3:0] s);
    bit err, any, tick, wok;
    bit [31:0] rd;
    bit [NUM_CH-1:0] exp, w1c;
    int ch;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_load[i] = 0; m_cmp[i] = 0; m_count[i] = 0;
        m_en[i] = 0; m_os[i] = 0; m_up[i] = 0; m_pwe[i] = 0; m_ie[i] = 0; m_pend[i] = 0;
      end
      m_ps = 0; m_pre = 0; m_ist = 0; m_trig = 0; m_pwm = 0; m_irq = 0;
      return;
    end
    m_decode(a, wr, err, rd);
    wok = acc && wr && !err;
    ch = int'(a[11:4]);
    any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) any |= m_en[i];
    tick = any && (m_pre == m_ps);
    m_irq = 1'b0;
    for (int i = 0; i < NUM_CH; i++) m_irq |= m_ist[i] & m_ie[i];
    exp = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_pwm[i] = m_en[i] && m_pwe[i] && (m_count[i] < m_cmp[i]);
      if (m_pend[i]) m_count[i] = m_up[i] ? 32'd0 : m_load[i];
      else if (m_en[i] && tick) begin
        if (m_count[i] == (m_up[i] ? m_load[i] : 32'd0)) begin
          exp[i] = 1'b1;
          m_count[i] = m_up[i] ? 32'd0 : m_load[i];
          if (m_os[i]) m_en[i] = 1'b0;
        end else
          m_count[i] = m_up[i] ? m_count[i] + 32'd1 : m_count[i] - 32'd1;
      end
      m_pend[i] = 1'b0;
    end
    if (wok && a < 12'h100)
      case (a[3:0])
        4'h0: if (s[0]) begin
          m_en[ch] = d[0]; m_os[ch] = d[1]; m_up[ch] = d[2];
          m_pwe[ch] = d[3]; m_ie[ch] = d[4]; m_pend[ch] = d[5];
        end
        4'h4: m_load[ch] = strb_merge(m_load[ch], d, s);
        4'h8: m_cmp[ch] = strb_merge(m_cmp[ch], d, s);
        default: ;
      endcase
    if (!any || (wok && a == 12'h100) || tick) m_pre = 0;
    else m_pre = m_pre + 32'd1;
    if (wok && a == 12'h100) m_ps = strb_merge(m_ps, d, s) & 32'h0000FFFF;
    w1c = (wok && a == 12'h104 && s[0]) ? d[NUM_CH-1:0] : '0;
    m_ist = (m_ist & ~w1c) | exp;
    m_trig = exp;
  endfunction

  task automatic cyc();
    bit r, ac, w;
    bit [11:0] a;
    bit [31:0] d;
    bit [3:0] s;
    r = preset; ac = psel && penable; w = pwrite; a = paddr; d = pwdata; s = pstrb;
    @(posedge pclk); #1;
    m_step(r, ac, w, a, d, s);
  endtask

  // Setup phase, then leave the access phase driven for the caller to inspect.
  task automatic bus(input bit [11:0] a, input bit w, input bit [31:0] d, input bit [3:0] s);
    psel = 1; penable = 0; paddr = a; pwrite = w; pwdata = d; pstrb = s;
    cyc();
    penable = 1; #1;
  endtask

  task automatic done();
    cyc();
    psel = 0; penable = 0; pwrite = 0; pstrb = 0;
  endtask

  task automatic wr(input bit [11:0] a, input bit [31:0] d, input bit [3:0] s);
    bus(a, 1'b1, d, s);
    done();
  endtask

  // Reads have no side effects, so a held access phase samples a register every cycle.
  task automatic hold_read(input bit [11:0] a);
    psel = 1; penable = 1; pwrite = 0; paddr = a; pwdata = 0; pstrb = 0; #1;
  endtask

  task automatic test_reset();
    preset = 1; cyc(); cyc(); preset = 0;
    n_chk++; if ({pwm_o, trigger_o, irq, pslverr} !== '0) $display("FAIL reset_outputs got=%0h exp=0", {pwm_o, trigger_o, irq, pslverr}); else n_pass++;
    n_chk++; if (prdata !== 32'd0 || pready !== 1'b1) $display("FAIL reset_idle_bus got prdata=%0h pready=%0b exp 0/1", prdata, pready); else n_pass++;
    bus(12'h00C, 1'b0, 0, 0);
    n_chk++; if (prdata !== 32'd0 || pslverr !== 1'b0) $display("FAIL reset_count got=%0h err=%0b exp=0", prdata, pslverr); else n_pass++;
    done();
  endtask

  task automatic test_periodic();
    int trig_k[$];
    int irq_k, g;
    bit saw_low;
    irq_k = -1;
    wr(12'h100, 0, 4'hF); wr(12'h004, 3, 4'hF); wr(12'h000, 32'h11, 4'hF);
    hold_read(12'h00C);
    for (int k = 0; k < 16; k++) begin
      cyc();
      n_chk++; if (prdata !== m_count[0]) $display("FAIL per_count k=%0d got=%0d exp=%0d", k, prdata, m_count[0]); else n_pass++;
      n_chk++; if (trigger_o !== m_trig || irq !== m_irq) $display("FAIL per_trig_irq k=%0d got=%0h/%0b exp=%0h/%0b", k, trigger_o, irq, m_trig, m_irq); else n_pass++;
      if (trigger_o[0]) trig_k.push_back(k);
      if (irq && irq_k < 0) irq_k = k;
    end
    n_chk++; if (trig_k.size() != 4 || trig_k[0] != 0 || trig_k[3] != 12) $display("FAIL per_trig_period got n=%0d exp n=4 every 4 cycles", trig_k.size()); else n_pass++;
    n_chk++; if (irq_k != 1) $display("FAIL per_irq_delay got=%0d exp=1", irq_k); else n_pass++;
    // Clear between expiries: wait for the reload value first.
    g = 0;
    while (prdata !== 32'd3 && g < 20) begin cyc(); g++; end
    n_chk++; if (prdata !== 32'd3) $display("FAIL per_wait_reload got=%0d exp=3", prdata); else n_pass++;
    wr(12'h104, 32'h1, 4'hF);
    hold_read(12'h00C);
    saw_low = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_chk++; if (irq !== m_irq) $display("FAIL w1c_irq k=%0d got=%0b exp=%0b", k, irq, m_irq); else n_pass++;
      if (!irq) saw_low = 1;
    end
    n_chk++; if (!saw_low) $display("FAIL w1c_clears_irq got=1 exp=0"); else n_pass++;
    // Clear landing on the expiry edge.
    g = 0;
    while (prdata !== 32'd1 && g < 20) begin cyc(); g++; end
    n_chk++; if (prdata !== 32'd1) $display("FAIL per_wait_one got=%0d exp=1", prdata); else n_pass++;
    wr(12'h104, 32'h1, 4'hF);
    bus(12'h104, 1'b0, 0, 0);
    n_chk++; if (prdata[0] !== 1'b1 || pslverr !== 1'b0) $display("FAIL w1c_vs_set got=%0h exp bit0=1", prdata); else n_pass++;
    done();
  endtask

  task automatic test_oneshot();
    bit [31:0] last;
    int ntrig, nchg, last_k;
    bit gap_ok;
    wr(12'h000, 0, 4'hF); wr(12'h100, 2, 4'hF); wr(12'h014, 5, 4'hF); wr(12'h010, 32'h7, 4'hF);
    hold_read(12'h01C);
    last = prdata; ntrig = 0; nchg = 0; last_k = -1; gap_ok = 1;
    for (int k = 0; k < 30; k++) begin
      cyc();
      n_chk++; if (prdata !== m_count[1] || trigger_o !== m_trig) $display("FAIL os_count k=%0d got=%0d/%0h exp=%0d/%0h", k, prdata, trigger_o, m_count[1], m_trig); else n_pass++;
      if (trigger_o[1]) ntrig++;
      if (prdata !== last) begin
        nchg++;
        if (last_k >= 0 && k - last_k != 3) gap_ok = 0;
        last_k = k; last = prdata;
      end
    end
    n_chk++; if (ntrig != 1) $display("FAIL os_single_trig got=%0d exp=1", ntrig); else n_pass++;
    n_chk++; if (nchg != 6 || !gap_ok) $display("FAIL os_steps got=%0d gap_ok=%0b exp=6/1", nchg, gap_ok); else n_pass++;
    bus(12'h010, 1'b0, 0, 0);
    n_chk++; if (prdata !== 32'h6) $display("FAIL os_en_cleared got=%0h exp=6", prdata); else n_pass++;
    done();
    hold_read(12'h01C);
    for (int k = 0; k < 5; k++) begin
      cyc();
      n_chk++; if (prdata !== 32'd0) $display("FAIL os_stopped k=%0d got=%0d exp=0", k, prdata); else n_pass++;
    end
  endtask

  task automatic test_pwm();
    int high;
    wr(12'h100, 0, 4'hF); wr(12'h024, 9, 4'hF); wr(12'h028, 3, 4'hF); wr(12'h020, 32'h9, 4'hF);
    hold_read(12'h02C);
    high = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      n_chk++; if (prdata !== m_count[2] || pwm_o !== m_pwm) $display("FAIL pwm_cyc k=%0d got=%0d/%0h exp=%0d/%0h", k, prdata, pwm_o, m_count[2], m_pwm); else n_pass++;
      if (k >= 10 && pwm_o[2]) high++;
    end
    n_chk++; if (high != 9) $display("FAIL pwm_duty got=%0d exp=9", high); else n_pass++;
  endtask

  task automatic test_errors();
    bit [11:0] bad [6] = '{12'h0C0, 12'h102, 12'h200, 12'h108, 12'h080, 12'h005};
    bit [31:0] saved;
    foreach (bad[j]) begin
      bus(bad[j], 1'b0, 0, 0);
      n_chk++; if (pslverr !== 1'b1 || prdata !== 32'd0) $display("FAIL err_read a=%0h got=%0b/%0h exp=1/0", bad[j], pslverr, prdata); else n_pass++;
      done();
    end
    saved = m_count[0];
    bus(12'h00C, 1'b1, 32'hDEAD, 4'hF);
    n_chk++; if (pslverr !== 1'b1) $display("FAIL err_wr_count got=%0b exp=1", pslverr); else n_pass++;
    done();
    bus(12'h00C, 1'b0, 0, 0);
    n_chk++; if (prdata !== saved || pslverr !== 1'b0) $display("FAIL err_count_kept got=%0h exp=%0h", prdata, saved); else n_pass++;
    done();
    bus(12'h0C4, 1'b1, 32'h55, 4'hF);
    n_chk++; if (pslverr !== 1'b1) $display("FAIL err_wr_badch got=%0b exp=1", pslverr); else n_pass++;
    done(); #1;
    n_chk++; if (pslverr !== 1'b0 || prdata !== 32'd0) $display("FAIL err_idle got=%0b/%0h exp=0/0", pslverr, prdata); else n_pass++;
  endtask

  task automatic test_strobe();
    wr(12'h034, 0, 4'hF);
    wr(12'h034, 32'hAABBCCDD, 4'b0101);
    bus(12'h034, 1'b0, 0, 0);
    n_chk++; if (prdata !== 32'h00BB00DD) $display("FAIL strb_load got=%0h exp=00bb00dd", prdata); else n_pass++;
    done();
    wr(12'h030, 32'h3F, 4'b0000);
    bus(12'h030, 1'b0, 0, 0);
    n_chk++; if (prdata !== 32'd0) $display("FAIL strb_ctrl_masked got=%0h exp=0", prdata); else n_pass++;
    done();
    wr(12'h030, 32'h20, 4'hF);
    bus(12'h03C, 1'b0, 0, 0);
    n_chk++; if (prdata !== 32'h00BB00DD) $display("FAIL load_cmd_count got=%0h exp=00bb00dd", prdata); else n_pass++;
    done();
    bus(12'h030, 1'b0, 0, 0);
    n_chk++; if (prdata !== 32'd0) $display("FAIL load_cmd_selfclear got=%0h exp=0", prdata); else n_pass++;
    done();
    wr(12'h100, 32'hFFFFFFFF, 4'hF);
    bus(12'h100, 1'b0, 0, 0);
    n_chk++; if (prdata !== 32'h0000FFFF) $display("FAIL pre_width got=%0h exp=ffff", prdata); else n_pass++;
    done();
    wr(12'h100, 0, 4'hF);
  endtask

  task automatic test_random();
    bit [11:0] addrs [16] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'h018, 12'h020,
                              12'h028, 12'h030, 12'h034, 12'h03C, 12'h100, 12'h104, 12'h0C0, 12'h102};
    bit [11:0] a;
    bit w, e;
    bit [31:0] d, ex;
    bit [3:0] s;
    for (int it = 0; it < 300; it++) begin
      a = addrs[$urandom_range(0, 15)];
      w = 1'($urandom_range(0, 1));
      if (a == 12'h100) d = $urandom_range(0, 3);
      else if (a == 12'h104) d = $urandom_range(0, 15);
      else if (a[3:0] == 4'h0) d = $urandom_range(0, 63);
      else d = $urandom_range(0, 12);
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      bus(a, w, d, s);
      m_decode(a, w, e, ex);
      n_chk++; if (pslverr !== e || prdata !== ex) $display("FAIL rnd_access it=%0d a=%0h got=%0b/%0h exp=%0b/%0h", it, a, pslverr, prdata, e, ex); else n_pass++;
      done();
      n_chk++; if (pwm_o !== m_pwm || trigger_o !== m_trig || irq !== m_irq) $display("FAIL rnd_outputs it=%0d got=%0h/%0h/%0b exp=%0h/%0h/%0b", it, pwm_o, trigger_o, irq, m_pwm, m_trig, m_irq); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    wr(12'h100, 0, 4'hF); wr(12'h008, 32'hFFFF, 4'hF); wr(12'h004, 5, 4'hF); wr(12'h000, 32'h19, 4'hF);
    hold_read(12'h00C);
    for (int k = 0; k < 9; k++) cyc();
    preset = 1;
    cyc();
    n_chk++; if (prdata !== 32'd0 || pwm_o !== '0 || irq !== 1'b0 || trigger_o !== '0) $display("FAIL reset_mid got cnt=%0h pwm=%0h irq=%0b trig=%0h exp all 0", prdata, pwm_o, irq, trigger_o); else n_pass++;
    preset = 0;
    psel = 0; penable = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_pwm();
    test_errors();
    test_strobe();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
